// File: rtl/data_cache_pkg.sv
// data_cache_pkg: state encoding and address-field helpers shared by the data cache files.
package data_cache_pkg;
  typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_DATA, REFILL_DONE} state_t;
  function automatic int offset_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction
  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_bits(input int addr_width, input int sets, input int words_per_line);
    return addr_width - 2 - $clog2(sets) - $clog2(words_per_line);
  endfunction
  // Extracts bits [lsb +: bits] of a byte address; callers size-cast the result.
  function automatic logic [63:0] get_field(input logic [63:0] addr, input int lsb, input int bits);
    return (addr >> lsb) & ((64'd1 << bits) - 64'd1);
  endfunction
endpackage

// File: rtl/data_cache_if.sv
// data_cache_if: core-side request/response and backing-memory signals of the data cache.
interface data_cache_if #(parameter int ADDR_WIDTH = 32);
  logic                  req_valid;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_be;
  logic [31:0]           rdata;
  logic                  stall;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_write;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [31:0]           mem_req_wdata;
  logic [3:0]            mem_req_be;
  logic                  mem_resp_valid;
  logic [31:0]           mem_resp_data;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  rdata, stall, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_be
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, mem_req_ready, mem_resp_valid, mem_resp_data,
    output rdata, stall, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_be
  );
endinterface

// File: rtl/data_cache_array.sv
// data_cache_array: valid/tag/data storage with a combinational read port and a byte-enabled word write port.
module data_cache_array import data_cache_pkg::*; #(
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_BITS       = 22,
  parameter int INDEX_BITS     = index_bits(SETS),
  parameter int OFFSET_BITS    = offset_bits(WORDS_PER_LINE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_BITS-1:0]  i_rd_index,
  input  logic [OFFSET_BITS-1:0] i_rd_offset,
  output logic                   o_rd_valid,
  output logic [TAG_BITS-1:0]    o_rd_tag,
  output logic [31:0]            o_rd_word,
  input  logic                   i_wr_en,
  input  logic [INDEX_BITS-1:0]  i_wr_index,
  input  logic [OFFSET_BITS-1:0] i_wr_offset,
  input  logic [31:0]            i_wr_data,
  input  logic [3:0]             i_wr_be,
  input  logic                   i_tag_en,
  input  logic [TAG_BITS-1:0]    i_tag
);
  logic [SETS-1:0]     r_valid;
  logic [TAG_BITS-1:0] r_tag [SETS];
  logic [31:0]         r_data [SETS*WORDS_PER_LINE];
  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_word  = r_data[{i_rd_index, i_rd_offset}];
  always_ff @(posedge clk)
    if (!rst) r_valid <= '0;
    else if (i_tag_en) r_valid[i_wr_index] <= 1'b1;
  // Tag and data carry no reset: a cleared valid bit already hides them.
  always_ff @(posedge clk) begin
    if (i_tag_en) r_tag[i_wr_index] <= i_tag;
    for (int b = 0; b < 4; b++)
      if (i_wr_en && i_wr_be[b]) r_data[{i_wr_index, i_wr_offset}][8*b +: 8] <= i_wr_data[8*b +: 8];
  end
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate L1 data cache with line refill on load miss.
module data_cache import data_cache_pkg::*; #(
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32
) (
  input logic        clk,
  input logic        rst,
  data_cache_if.slave bus
);
  localparam int OB = offset_bits(WORDS_PER_LINE);
  localparam int IB = index_bits(SETS);
  localparam int TB = tag_bits(ADDR_WIDTH, SETS, WORDS_PER_LINE);
  state_t        r_state;
  logic [OB-1:0] r_cnt;
  logic [IB-1:0] r_index;
  logic [TB-1:0] r_tag;
  logic [63:0]   w_addr;
  logic [OB-1:0] w_offset;
  logic [IB-1:0] w_index;
  logic [TB-1:0] w_tag, w_arr_tag;
  logic [31:0]   w_word;
  logic w_arr_valid, w_hit, w_idle, w_req_rd, w_refill, w_load, w_store, w_miss, w_fill, w_last, w_st_hit;
  assign w_addr   = 64'(bus.req_addr);
  assign w_offset = OB'(get_field(w_addr, 2, OB));
  assign w_index  = IB'(get_field(w_addr, 2 + OB, IB));
  assign w_tag    = TB'(get_field(w_addr, 2 + OB + IB, TB));
  assign w_hit    = w_arr_valid && w_arr_tag == w_tag;
  assign w_idle   = r_state == IDLE;
  assign w_req_rd = rst && r_state == REFILL_REQ;
  assign w_refill = w_req_rd || (rst && r_state == REFILL_DATA);
  assign w_load   = rst && bus.req_valid && !bus.req_write;
  assign w_store  = rst && bus.req_valid && bus.req_write && w_idle;
  assign w_miss   = w_load && w_idle && !w_hit;
  assign w_fill   = rst && r_state == REFILL_DATA && bus.mem_resp_valid;
  assign w_last   = w_fill && &r_cnt;
  assign w_st_hit = w_store && bus.mem_req_ready && w_hit;
  // Load data is only meaningful when the addressed line is stable: in IDLE or the replay cycle.
  assign bus.rdata         = w_load && w_hit && (w_idle || r_state == REFILL_DONE) ? w_word : '0;
  assign bus.stall         = w_miss || w_refill || (w_store && !bus.mem_req_ready);
  assign bus.mem_req_valid = w_req_rd || w_store;
  assign bus.mem_req_write = w_store;
  assign bus.mem_req_addr  = w_store ? {bus.req_addr[ADDR_WIDTH-1:2], 2'b00} :
                             w_req_rd ? {r_tag, r_index, {OB{1'b0}}, 2'b00} : '0;
  assign bus.mem_req_wdata = w_store ? bus.req_wdata : '0;
  assign bus.mem_req_be    = w_store ? bus.req_be : '0;
  data_cache_array #(.SETS(SETS), .WORDS_PER_LINE(WORDS_PER_LINE), .TAG_BITS(TB)) u_array (
    .clk         (clk),
    .rst         (rst),
    .i_rd_index  (w_index),
    .i_rd_offset (w_offset),
    .o_rd_valid  (w_arr_valid),
    .o_rd_tag    (w_arr_tag),
    .o_rd_word   (w_word),
    .i_wr_en     (w_fill || w_st_hit),
    .i_wr_index  (w_fill ? r_index : w_index),
    .i_wr_offset (w_fill ? r_cnt : w_offset),
    .i_wr_data   (w_fill ? bus.mem_resp_data : bus.req_wdata),
    .i_wr_be     (w_fill ? 4'hF : bus.req_be),
    .i_tag_en    (w_last),
    .i_tag       (r_tag)
  );
  // The beat counter wraps to zero after the last beat, ready for the next refill.
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_miss) begin
          r_state <= REFILL_REQ;
          r_index <= w_index;
          r_tag   <= w_tag;
        end
        REFILL_REQ:  if (bus.mem_req_ready) r_state <= REFILL_DATA;
        REFILL_DATA: if (w_last) r_state <= REFILL_DONE;
        default:     r_state <= IDLE;
      endcase
      if (w_fill) r_cnt <= r_cnt + OB'(1);
    end
endmodule
